reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 90 +++++++++
 tb/tb_reg_bank.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: general-purpose register file with dedicated PC/SP/SR ports, constant
// generator on R2/R3, post-increment and prioritised same-cycle update arbitration.
module reg_bank #(
  parameter int          DW     = 16,
  parameter int          NREG   = 16,
  parameter logic [15:0] PC_RST = 16'h0000,
  parameter logic [15:0] SP_RST = 16'h0400,
  parameter bit          CG_EN  = 1'b1,
  localparam int         AW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] SA,
  input  logic [AW-1:0] DA,
  input  logic [1:0]    As,
  input  logic [DW-1:0] Din,
  input  logic          RW,
  input  logic          inc_en,
  input  logic          inc_byte,
  input  logic [DW-1:0] reg_PC_in,
  input  logic [DW-1:0] reg_SP_in,
  input  logic [DW-1:0] reg_SR_in,
  input  logic          reg_PC_ld,
  input  logic          reg_SP_ld,
  input  logic          reg_SR_ld,
  output logic [DW-1:0] Sout,
  output logic [DW-1:0] Dout,
  output logic [DW-1:0] reg_PC_out,
  output logic [DW-1:0] reg_SP_out,
  output logic [DW-1:0] reg_SR_out,
  output logic          wr_conflict
);
  logic [DW-1:0]   r_regs [NREG];
  logic            r_cf;
  logic [DW-1:0]   w_sa_reg, w_da_reg, w_inc_val, w_step;
  logic            w_cg2, w_cg3, w_inc, w_cf;
  logic [NREG-1:0] w_wr, w_in, w_ld, w_upd;
  logic [DW-1:0]   w_next [NREG];
  // Address decode by match loop: out-of-range addresses simply match nothing and read 0.
  always_comb begin
    w_sa_reg = '0;
    w_da_reg = '0;
    for (int i = 0; i < NREG; i++) begin
      if (SA == AW'(i) && i != 3) w_sa_reg = r_regs[i];
      if (DA == AW'(i) && i != 3) w_da_reg = r_regs[i];
    end
  end
  assign w_cg2 = CG_EN && SA == AW'(2) && As != 2'b00;
  assign w_cg3 = CG_EN && SA == AW'(3);
  always_comb begin
    Sout = w_sa_reg;
    if (w_cg3)
      Sout = As == 2'b11 ? '1 : DW'(As);
    else if (w_cg2)
      Sout = As == 2'b01 ? DW'(0) : As == 2'b10 ? DW'(4) : DW'(8);
  end
  assign Dout       = w_da_reg;
  assign reg_PC_out = r_regs[0];
  assign reg_SP_out = r_regs[1];
  assign reg_SR_out = r_regs[2];
  assign wr_conflict = r_cf;
  assign w_inc     = inc_en && As == 2'b11 && !(w_cg2 || w_cg3);
  assign w_step    = (SA == AW'(0) || SA == AW'(1) || !inc_byte) ? DW'(2) : DW'(1);
  assign w_inc_val = w_sa_reg + w_step;
  // Per-register arbitration: write > increment > dedicated load; R3 never updates.
  always_comb begin
    w_cf = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_wr[i]   = RW && DA == AW'(i) && i != 3;
      w_in[i]   = w_inc && SA == AW'(i) && i != 3;
      w_ld[i]   = i == 0 ? reg_PC_ld : i == 1 ? reg_SP_ld : i == 2 ? reg_SR_ld : 1'b0;
      w_upd[i]  = w_wr[i] || w_in[i] || w_ld[i];
      w_next[i] = w_wr[i] ? Din : w_in[i] ? w_inc_val :
                  i == 0 ? reg_PC_in : i == 1 ? reg_SP_in : reg_SR_in;
      if (i < 2) w_next[i][0] = 1'b0;
      if ((w_wr[i] && (w_in[i] || w_ld[i])) || (w_in[i] && w_ld[i])) w_cf = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= i == 0 ? DW'(PC_RST) : i == 1 ? DW'(SP_RST) : '0;
      r_cf <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (w_upd[i]) r_regs[i] <= w_next[i];
      r_cf <= w_cf;
    end
  end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed vectors with hand-computed expectations for reg_bank.
module tb_reg_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  SA, DA;
  logic [1:0]  As;
  logic [15:0] Din;
  logic        RW, inc_en, inc_byte;
  logic [15:0] reg_PC_in, reg_SP_in, reg_SR_in;
  logic        reg_PC_ld, reg_SP_ld, reg_SR_ld;
  logic [15:0] Sout, Dout, reg_PC_out, reg_SP_out, reg_SR_out;
  logic        wr_conflict;
  int n_chk = 0;
  int n_pass = 0;
  reg_bank dut (
    .clk(clk), .rst(rst), .SA(SA), .DA(DA), .As(As), .Din(Din), .RW(RW),
    .inc_en(inc_en), .inc_byte(inc_byte),
    .reg_PC_in(reg_PC_in), .reg_SP_in(reg_SP_in), .reg_SR_in(reg_SR_in),
    .reg_PC_ld(reg_PC_ld), .reg_SP_ld(reg_SP_ld), .reg_SR_ld(reg_SR_ld),
    .Sout(Sout), .Dout(Dout),
    .reg_PC_out(reg_PC_out), .reg_SP_out(reg_SP_out), .reg_SR_out(reg_SR_out),
    .wr_conflict(wr_conflict)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic idle();
    rst = 0; SA = 0; DA = 0; As = 0; Din = 0; RW = 0; inc_en = 0; inc_byte = 0;
    reg_PC_in = 0; reg_SP_in = 0; reg_SR_in = 0;
    reg_PC_ld = 0; reg_SP_ld = 0; reg_SR_ld = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [3:0] a, input string tag, input logic [15:0] exp);
    DA = a;
    #1;
    chk(tag, Dout, exp);
  endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    idle(); RW = 1; DA = a; Din = d;
    tick();
    idle();
  endtask
  task automatic inc(input logic [3:0] a, input logic b);
    idle(); SA = a; As = 2'b11; inc_en = 1; inc_byte = b;
    tick();
    idle();
  endtask
  logic [15:0] cg_exp [8] = '{16'h0107, 16'h0000, 16'h0004, 16'h0008,
                              16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
  initial begin
    idle();
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("rst_pc", reg_PC_out, 16'h0000);
    chk("rst_sp", reg_SP_out, 16'h0400);
    chk("rst_sr", reg_SR_out, 16'h0000);
    chk("rst_cf", {15'b0, wr_conflict}, 16'h0000);
    for (int i = 0; i < 16; i++)
      rd(4'(i), $sformatf("rst_dout%0d", i), i == 1 ? 16'h0400 : 16'h0000);
    idle(); RW = 1; DA = 5; Din = 16'hA5A5;
    #1;
    chk("no_bypass", Dout, 16'h0000);
    tick();
    idle(); SA = 5; As = 2'b00;
    #1;
    chk("rw_sout5", Sout, 16'hA5A5);
    wr(3, 16'h1234);
    rd(3, "r3_wr_dropped", 16'h0000);
    chk("r3_cf", {15'b0, wr_conflict}, 16'h0000);
    idle(); reg_SR_ld = 1; reg_SR_in = 16'h0107;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      SA = i < 4 ? 4'd2 : 4'd3;
      As = 2'(i);
      #1;
      chk($sformatf("cg_sa%0d_as%0d", SA, As), Sout, cg_exp[i]);
    end
    wr(4, 16'hFFFF);
    inc(4, 0);
    rd(4, "inc_wrap", 16'h0001);
    inc(4, 1);
    rd(4, "inc_byte_r4", 16'h0002);
    inc(1, 1);
    chk("inc_byte_sp", reg_SP_out, 16'h0402);
    idle(); SA = 3; As = 2'b11; inc_en = 1;
    #1;
    chk("cg_sa3_inc_sout", Sout, 16'hFFFF);
    tick();
    idle();
    rd(3, "inc_r3", 16'h0000);
    rd(4, "inc_r3_r4", 16'h0002);
    chk("inc_r3_sp", reg_SP_out, 16'h0402);
    idle(); SA = 2; As = 2'b11; inc_en = 1;
    tick();
    idle();
    chk("inc_r2_cg", reg_SR_out, 16'h0107);
    wr(1, 16'h1235);
    chk("sp_bit0", reg_SP_out, 16'h1234);
    wr(4, 16'h0010);
    idle(); RW = 1; DA = 4; Din = 16'h0050; SA = 4; As = 2'b11; inc_en = 1;
    tick();
    idle();
    rd(4, "col_wr_inc", 16'h0050);
    chk("col_cf1", {15'b0, wr_conflict}, 16'h0001);
    tick();
    chk("col_cf0", {15'b0, wr_conflict}, 16'h0000);
    idle(); RW = 1; DA = 0; Din = 16'h8001; reg_PC_ld = 1; reg_PC_in = 16'h2000;
    tick();
    idle();
    chk("col_pc", reg_PC_out, 16'h8000);
    chk("col_pc_cf", {15'b0, wr_conflict}, 16'h0001);
    idle(); RW = 1; DA = 5; Din = 16'h1111; SA = 4; As = 2'b11; inc_en = 1;
    reg_SP_ld = 1; reg_SP_in = 16'h0301;
    tick();
    idle();
    rd(5, "par_r5", 16'h1111);
    rd(4, "par_r4", 16'h0052);
    chk("par_sp", reg_SP_out, 16'h0300);
    chk("par_cf", {15'b0, wr_conflict}, 16'h0000);
    idle(); RW = 1; DA = 4; Din = 16'h0070; SA = 4; As = 2'b11; inc_en = 1;
    tick();
    idle(); rst = 1; RW = 1; DA = 5; Din = 16'h9999; SA = 4; As = 2'b11; inc_en = 1;
    reg_PC_ld = 1; reg_PC_in = 16'h1000; reg_SP_ld = 1; reg_SP_in = 16'h2000;
    reg_SR_ld = 1; reg_SR_in = 16'h3000;
    tick();
    idle();
    chk("rstc_pc", reg_PC_out, 16'h0000);
    chk("rstc_sp", reg_SP_out, 16'h0400);
    chk("rstc_sr", reg_SR_out, 16'h0000);
    chk("rstc_cf", {15'b0, wr_conflict}, 16'h0000);
    rd(5, "rstc_r5", 16'h0000);
    rd(4, "rstc_r4", 16'h0000);
    tick();
    chk("rstc_cf_after", {15'b0, wr_conflict}, 16'h0000);
    chk("rstc_pc_after", reg_PC_out, 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
